// File: rtl/uart_tx_fifo.sv
// Byte FIFO on clk feeding the UART through its wr/tbe level handshake.
// Enforces a wr-low gap between bytes so the UART drains back to IDLE.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               uart_data,
  output logic                     uart_wr,
  input  logic                     uart_tbe,
  output logic [1:0]               state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_GAP  = 2'd0,
    S_IDLE = 2'd1,
    S_REQ  = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            tbe_m;
  logic            tbe_s;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_nxt;

  assign state_dbg = state;

  // The feeder pops only from IDLE; a push at full is accepted when it
  // coincides with that pop.
  assign pop  = (state == S_IDLE) && !empty;
  assign push = wr_en && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  // tbe comes from the UART's txclk domain; idle level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbe_m <= 1'b1;
      tbe_s <= 1'b1;
    end else begin
      tbe_m <= uart_tbe;
      tbe_s <= tbe_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_GAP;
      gap_cnt   <= GAP_LOAD;
      uart_wr   <= 1'b0;
      uart_data <= 8'h00;
    end else begin
      case (state)
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        S_IDLE: begin
          if (!empty) begin
            uart_data <= mem[rptr];
            uart_wr   <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (!tbe_s) state <= S_BUSY;
        end
        S_BUSY: begin
          // tbe back high means the stop bit went out; drop wr for the gap.
          if (tbe_s) begin
            uart_wr <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        default: begin
          uart_wr <= 1'b0;
          gap_cnt <= GAP_LOAD;
          state   <= S_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART on a divided txclk.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int GAP   = 20;
  localparam int TXDIV = 3;   // txclk period 2*(TXDIV+1) = 8 clk cycles
  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_BUSY = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] uart_data;
  logic       uart_wr;
  logic       uart_tbe = 1'b1;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .uart_data(uart_data), .uart_wr(uart_wr), .uart_tbe(uart_tbe),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int   div = 0;
  logic txclk = 1'b0;
  always @(posedge clk) begin
    if (div == TXDIV) begin
      div   <= 0;
      txclk <= ~txclk;
    end else begin
      div <= div + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- UART model (no reset, like the real block) ----------------
  typedef enum int {M_IDLE, M_START, M_DATA, M_STOP, M_END} m_t;
  m_t         m_st = M_IDLE;
  logic       model_en = 1'b1;
  logic [7:0] shreg = 8'h00;
  int         bit_i = 0;
  logic [8:0] frame = '0;
  logic [9:0] last_frame = '0;
  int         rx_cnt = 0;
  int         end_stall = 0;

  always @(posedge txclk) begin
    case (m_st)
      M_IDLE: if (uart_wr && model_en) begin
        shreg    <= uart_data;
        uart_tbe <= 1'b0;
        m_st     <= M_START;
      end
      M_START: begin
        frame[0] <= 1'b0;
        bit_i    <= 0;
        m_st     <= M_DATA;
      end
      M_DATA: begin
        frame[bit_i+1] <= shreg[bit_i];
        bit_i          <= bit_i + 1;
        if (bit_i == 7) m_st <= M_STOP;
      end
      M_STOP: begin : sb
        logic [8:0] e;
        e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check("sb_byte", {24'd0, frame[8:1]}, {23'd0, e});
        last_frame <= {1'b1, frame};
        uart_tbe   <= 1'b1;
        rx_cnt     <= rx_cnt + 1;
        m_st       <= M_END;
      end
      M_END: begin
        if (!uart_wr) m_st <= M_IDLE;
        else          end_stall <= end_stall + 1;
      end
      default: m_st <= M_IDLE;
    endcase
  end

  // wr-low periods: length in clk cycles and whether a txclk rise fell inside
  int   low_len = 0;
  int   gap_viol = 0;
  logic txclk_prev = 1'b0;
  logic wr_prev = 1'b0;
  logic tx_seen = 1'b0;
  always @(posedge clk) begin
    txclk_prev <= txclk;
    wr_prev    <= uart_wr;
    if (!uart_wr) begin
      low_len <= low_len + 1;
      if (txclk && !txclk_prev) tx_seen <= 1'b1;
    end else if (!wr_prev) begin
      if (low_len < GAP || !tx_seen) gap_viol <= gap_viol + 1;
      low_len <= 0;
      tx_seen <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(state_dbg == ST_IDLE && m_st == M_IDLE && exp_q.size() == 0) && n < 6000) begin
      tick();
      n++;
    end
    check(tag, n < 6000, 1);
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (state_dbg != s && n < 2000) begin
      tick();
      n++;
    end
    check(tag, state_dbg, s);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int   n;
    logic stable;
    logic any_high;

    // Reset values
    tick(); tick(); tick();
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_uart_wr", uart_wr, 0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_state", state_dbg, ST_GAP);

    // First byte after reset waits out the whole gap, then IDLE
    #2 rst_n = 1'b1;
    exp_q.push_back(8'h3C);
    push(8'h3C);
    check("p1_count", count, 1);
    check("p1_empty", empty, 0);
    n = 1;
    while (!uart_wr && n < 200) begin
      tick();
      n++;
    end
    check("post_reset_wr_latency", n, GAP + 1);
    check("p1_data", uart_data, 8'h3C);
    check("p1_count_after_pop", count, 0);
    wait_drain("drain_3c");

    // Single byte 0xA5: start latency, stability, frame, wr release
    exp_q.push_back(8'hA5);
    push(8'hA5);
    check("a5_empty_falls", empty, 0);
    check("a5_wr_not_yet", uart_wr, 0);
    tick();
    check("a5_wr_rises", uart_wr, 1);
    check("a5_data", uart_data, 8'hA5);
    check("a5_empty_again", empty, 1);
    n = 0;
    stable = 1'b1;
    while (uart_tbe && n < 200) begin
      if (uart_data !== 8'hA5) stable = 1'b0;
      tick();
      n++;
    end
    check("a5_tbe_fall_seen", n < 200, 1);
    check("a5_data_stable", stable, 1);
    n = 0;
    while (!uart_tbe && n < 400) begin
      tick();
      n++;
    end
    check("a5_tbe_rise_seen", n < 400, 1);
    check("a5_frame", last_frame, 10'b11_0100_1010);
    n = 0;
    while (uart_wr && n < 10) begin
      tick();
      n++;
    end
    check("a5_wr_fall_within_3", (n <= 3) && !uart_wr, 1);
    wait_drain("drain_a5");

    // Burst 0x00..0x0F; the feeder pops 0x00 on the second cycle
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    check("burst_count15", count, 15);
    check("burst_not_full", full, 0);
    exp_q.push_back(8'h10);
    push(8'h10);
    check("burst_count16", count, 16);
    check("burst_full", full, 1);
    check("burst_head_data", uart_data, 8'h00);
    wait_drain("drain_burst");

    // Overflow with the UART withholding tbe
    model_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      push(8'h40 + 8'(i));
    end
    check("ovf_count_full", count, 16);
    check("ovf_full", full, 1);
    check("ovf_not_yet", overflow, 0);
    check("ovf_req_state", state_dbg, ST_REQ);
    push(8'hFF);
    check("ovf_drop_count", count, 16);
    check("ovf_set", overflow, 1);
    tick();
    check("ovf_sticky", overflow, 1);
    model_en = 1'b1;
    wait_state(ST_IDLE, "ovf_reach_idle");
    exp_q.push_back(8'h60);
    push(8'h60);
    check("pushpop_count", count, 16);
    check("pushpop_full", full, 1);
    check("pushpop_wr", uart_wr, 1);
    check("pushpop_data", uart_data, 8'h41);
    check("ovf_still_set", overflow, 1);
    wait_drain("drain_ovf");

    // Reset mid-BUSY discards queued bytes; the latched one still goes out
    exp_q.push_back(8'h77);
    push(8'h77);
    push(8'h78);
    push(8'h79);
    wait_state(ST_BUSY, "mid_busy_reached");
    check("mid_busy_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr", uart_wr, 0);
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_overflow", overflow, 0);
    n = 0;
    while (m_st != M_IDLE && n < 2000) begin
      tick();
      n++;
    end
    check("uart_drained_in_reset", n < 2000, 1);
    #2 rst_n = 1'b1;
    exp_q.push_back(8'h88);
    push(8'h88);
    any_high = uart_wr;
    for (int i = 1; i < GAP; i++) begin
      tick();
      any_high = any_high | uart_wr;
    end
    check("post_rst_gap_wr_low", any_high, 0);
    tick();
    check("post_rst_wr_rises", uart_wr, 1);
    check("post_rst_data", uart_data, 8'h88);
    wait_drain("drain_88");

    // Whole-run properties
    check("gap_violations", gap_viol, 0);
    check("uart_end_stalls", end_stall, 0);
    check("bytes_received", rx_cnt, 39);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
